// File: rtl/lsu_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pipe_if : request/response and data-memory bus for lsu_pipe       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface lsu_pipe_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_fun3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  // master = execute stage plus data memory; slave = the load/store unit
  modport master (
    output req_valid, req_store, req_fun3, req_addr, req_wdata, rsp_ready,
           mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    input  req_valid, req_store, req_fun3, req_addr, req_wdata, rsp_ready,
           mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pipe : RV32I/RV64I load/store unit, one aligned memory access per |
// | request. Define LSU_RMW_EN for read-modify-write sub-word stores.     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_pipe #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  lsu_pipe_if.slave bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("lsu_pipe: XLEN must be 32 or 64");
    end
  endgenerate

`ifdef LSU_RMW_EN
  typedef enum logic [2:0] {IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, RESP = 3'd3, MERGE = 3'd4} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
`endif

  state_t            r_state, w_next;
  logic              r_store, r_err;
  logic [2:0]        r_fun3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata, r_rdata;

  logic              w_legal, w_misal, w_bad, w_sign, w_we, w_rmw, w_rmw_rd;
  logic [OFFW-1:0]   w_off;
  int                w_szb;
  logic [NB-1:0]     w_be_sub;
  logic [XLEN-1:0]   w_rep, w_shift, w_ext, w_wdata_out;

  // Legality and alignment are judged on the live request, at accept time
  always_comb begin
    w_legal = 1'b0;
    if (bus.req_store) begin
      case (bus.req_fun3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        3'b011:                 w_legal = (XLEN == 64);
        default:                w_legal = 1'b0;
      endcase
    end else begin
      case (bus.req_fun3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        3'b011, 3'b110:                         w_legal = (XLEN == 64);
        default:                                w_legal = 1'b0;
      endcase
    end
    case (bus.req_fun3[1:0])
      2'b01:   w_misal = bus.req_addr[0];
      2'b10:   w_misal = |bus.req_addr[1:0];
      2'b11:   w_misal = |bus.req_addr[2:0];
      default: w_misal = 1'b0;
    endcase
    w_bad = ~w_legal | w_misal;
  end

  assign w_off = r_addr[OFFW-1:0];

  always_comb begin
    w_szb = 1 << r_fun3[1:0];
    if (w_szb > NB) w_szb = NB;
    w_shift = bus.mem_rdata >> {w_off, 3'b000};
    w_sign  = ~r_fun3[2] & w_shift[8*w_szb-1];
    for (int i = 0; i < NB; i++) begin
      w_be_sub[i]     = (i >= int'(w_off)) && (i < int'(w_off) + w_szb);
      w_rep[8*i +: 8] = r_wdata[8*(i & (w_szb - 1)) +: 8];
      w_ext[8*i +: 8] = (i < w_szb) ? w_shift[8*i +: 8] : {8{w_sign}};
    end
  end

`ifdef LSU_RMW_EN
  logic            r_wr_phase;
  logic [XLEN-1:0] w_merge;

  assign w_rmw       = r_store & (w_szb < NB);
  assign w_rmw_rd    = w_rmw & ~r_wr_phase;
  assign w_wdata_out = r_wr_phase ? r_wdata : w_rep;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      w_merge[8*i +: 8] = w_be_sub[i] ? w_rep[8*i +: 8] : r_rdata[8*i +: 8];
    end
  end
`else
  assign w_rmw       = 1'b0;
  assign w_rmw_rd    = 1'b0;
  assign w_wdata_out = w_rep;
`endif

  assign w_we = r_store & ~w_rmw_rd;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_rdata  = '0;
    bus.rsp_err    = 1'b0;
    bus.mem_valid  = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_be     = '0;
    bus.mem_wdata  = '0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = w_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.mem_valid = 1'b1;
        bus.mem_we    = w_we;
        bus.mem_addr  = {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        bus.mem_be    = (r_store & ~w_rmw) ? w_be_sub : '1;
        bus.mem_wdata = w_we ? w_wdata_out : '0;
        if (bus.mem_ready) w_next = w_we ? RESP : WAIT;
      end
      WAIT: begin
`ifdef LSU_RMW_EN
        if (bus.mem_rvalid) w_next = w_rmw ? MERGE : RESP;
`else
        if (bus.mem_rvalid) w_next = RESP;
`endif
      end
`ifdef LSU_RMW_EN
      MERGE: w_next = ISSUE;
`endif
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = r_rdata;
        bus.rsp_err   = r_err;
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_store <= 1'b0;
      r_err   <= 1'b0;
      r_fun3  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef LSU_RMW_EN
      r_wr_phase <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE && bus.req_valid) begin
        r_store <= bus.req_store;
        r_fun3  <= bus.req_fun3;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_err   <= w_bad;
        r_rdata <= '0;
`ifdef LSU_RMW_EN
        r_wr_phase <= 1'b0;
`endif
      end
      // An RMW read keeps the raw word for merging; a load keeps the extended value
      if (r_state == WAIT && bus.mem_rvalid) r_rdata <= w_rmw ? bus.mem_rdata : w_ext;
`ifdef LSU_RMW_EN
      if (r_state == MERGE) begin
        r_wdata    <= w_merge;
        r_rdata    <= '0;
        r_wr_phase <= 1'b1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lsu_pipe : directed self-checking bench for lsu_pipe, XLEN = 32    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lsu_pipe;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  lsu_pipe_if #(.XLEN(32), .ADDR_W(32)) bus ();
  lsu_pipe #(.XLEN(32), .ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_fun3  = f3;
    bus.req_addr  = a;
    bus.req_wdata = d;
    check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Zero-wait load: handshake in the first ISSUE cycle, data the cycle after
  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] rd, input logic [31:0] exp);
    bus.mem_ready = 1'b1;
    send(1'b0, f3, a, 32'h0);
    check({tag, "_issue_valid"}, 32'(bus.mem_valid), 32'd1);
    check({tag, "_issue_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_issue_be"}, 32'(bus.mem_be), 32'hF);
    check({tag, "_issue_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    tick();
    check({tag, "_wait_rsp"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_wait_memvalid"}, 32'(bus.mem_valid), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    tick();
    bus.mem_rvalid = 1'b0;
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, exp);
    tick();
  endtask

  task automatic err_req(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a);
    send(st, f3, a, 32'hFFFF_FFFF);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd1);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    check({tag, "_no_mem"}, 32'(bus.mem_valid), 32'd0);
    tick();
    check({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_still_no_mem"}, 32'(bus.mem_valid), 32'd0);
  endtask

  // Store with byte enables, mem_ready already high
  task automatic store_be(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input logic [31:0] wd);
    bus.mem_ready = 1'b1;
    send(1'b1, f3, a, d);
    check({tag, "_valid"}, 32'(bus.mem_valid), 32'd1);
    check({tag, "_we"}, 32'(bus.mem_we), 32'd1);
    check({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    check({tag, "_be"}, 32'(bus.mem_be), 32'(be));
    check({tag, "_wdata"}, bus.mem_wdata, wd);
    check({tag, "_no_rsp_yet"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    check({tag, "_mem_idle"}, 32'(bus.mem_valid), 32'd0);
    tick();
    check({tag, "_back_idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_fun3   = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_be", 32'(bus.mem_be), 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;
    tick();

`ifndef LSU_RMW_EN
    store_be("sb", 3'b000, 32'h8000_0006, 32'h0000_00A5, 4'b0100, 32'hA5A5_A5A5);
    store_be("sh", 3'b001, 32'h8000_0002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
    store_be("sw", 3'b010, 32'h8000_000C, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    store_be("sb0", 3'b000, 32'h8000_0000, 32'hFFFF_FF3C, 4'b0001, 32'h3C3C_3C3C);
`endif

    load("lb3", 3'b000, 32'h8000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
    load("lbu3", 3'b100, 32'h8000_0003, 32'h80FF_1234, 32'h0000_0080);
    load("lb1", 3'b000, 32'h8000_0001, 32'h80FF_1234, 32'h0000_0012);
    load("lh2", 3'b001, 32'h8000_0002, 32'h80FF_1234, 32'hFFFF_80FF);
    load("lhu2", 3'b101, 32'h8000_0002, 32'h80FF_1234, 32'h0000_80FF);
    load("lw", 3'b010, 32'h8000_0004, 32'h80FF_1234, 32'h80FF_1234);

    err_req("lh_mis", 1'b0, 3'b001, 32'h8000_0001);
    err_req("lw_mis", 1'b0, 3'b010, 32'h8000_0002);
    err_req("sw_mis", 1'b1, 3'b010, 32'h8000_0001);
    err_req("st_f3_4", 1'b1, 3'b100, 32'h8000_0000);
    err_req("ld_rv32", 1'b0, 3'b011, 32'h8000_0000);
    err_req("lwu_rv32", 1'b0, 3'b110, 32'h8000_0000);
    err_req("ld_f3_7", 1'b0, 3'b111, 32'h8000_0000);

    // Memory stalls in ISSUE and WAIT, then consumer back-pressure in RESP
    bus.mem_ready = 1'b0;
    send(1'b0, 3'b010, 32'h8000_0008, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(bus.mem_valid), 32'd1);
      check("stall_addr", bus.mem_addr, 32'h8000_0008);
      check("stall_be", 32'(bus.mem_be), 32'hF);
      check("stall_we", 32'(bus.mem_we), 32'd0);
      tick();
    end
    bus.mem_ready = 1'b1;
    check("stall_release_valid", 32'(bus.mem_valid), 32'd1);
    tick();
    bus.mem_ready = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8000_0001;
    for (int i = 0; i < 3; i++) begin
      check("wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check("wait_no_accept", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.req_valid  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      check("hold_rsp_err", 32'(bus.rsp_err), 32'd0);
      if (i < 2) tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("hold_done_ready", 32'(bus.req_ready), 32'd1);
    check("hold_done_rsp", 32'(bus.rsp_valid), 32'd0);

    // Reset in WAIT abandons the load; the late read data must be ignored
    bus.mem_ready = 1'b1;
    send(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("mid_rst_mem_be", 32'(bus.mem_be), 32'h0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    tick();
    bus.mem_rvalid = 1'b0;
    check("late_rvalid_rsp", 32'(bus.rsp_valid), 32'd0);
    check("late_rvalid_ready", 32'(bus.req_ready), 32'd1);
    tick();
    check("late_rvalid_rsp2", 32'(bus.rsp_valid), 32'd0);

`ifdef LSU_RMW_EN
    bus.mem_ready = 1'b1;
    send(1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF);
    check("rmw_rd_valid", 32'(bus.mem_valid), 32'd1);
    check("rmw_rd_we", 32'(bus.mem_we), 32'd0);
    check("rmw_rd_be", 32'(bus.mem_be), 32'hF);
    check("rmw_rd_addr", bus.mem_addr, 32'h8000_0000);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1122_3344;
    check("rmw_wait_idle", 32'(bus.mem_valid), 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    check("rmw_merge_no_mem", 32'(bus.mem_valid), 32'd0);
    check("rmw_merge_no_rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("rmw_wr_valid", 32'(bus.mem_valid), 32'd1);
    check("rmw_wr_we", 32'(bus.mem_we), 32'd1);
    check("rmw_wr_be", 32'(bus.mem_be), 32'hF);
    check("rmw_wr_addr", bus.mem_addr, 32'h8000_0000);
    check("rmw_wr_wdata", bus.mem_wdata, 32'hBEEF_3344);
    tick();
    check("rmw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rmw_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rmw_rsp_rdata", bus.rsp_rdata, 32'h0);
    tick();
    check("rmw_idle", 32'(bus.req_ready), 32'd1);
    store_be_full: begin
      send(1'b1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D);
      check("rmw_sw_we", 32'(bus.mem_we), 32'd1);
      check("rmw_sw_wdata", bus.mem_wdata, 32'hCAFE_F00D);
      tick();
      check("rmw_sw_rsp", 32'(bus.rsp_valid), 32'd1);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_pipe.md
Name: lsu_pipe

Overview:
- Parametrised load/store unit between the RV32I execute stage and a word-organised data memory; generalises the existing byte-lane store and load-extend logic.
- Takes one load or store request per handshake, issues one aligned memory transaction, lane-aligns and extends read data, and returns a single response.
- Detects misaligned and illegal accesses without touching memory.
- Supports XLEN 32 or 64 and a memory with variable latency.

Parameters:
XLEN, 32, data width in bits; legal values 32 or 64
ADDR_W, 32, address width in bits
NB, XLEN/8, byte lanes (derived; must not be overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  unit can accept a request
req_store  in  1  1 = store, 0 = load
req_fun3  in  3  RISC-V funct3 width/sign code
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, low-justified
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  XLEN  load result, extended; 0 for stores and errors
rsp_err  out  1  misaligned or illegal access
mem_valid  out  1  memory request valid
mem_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_addr  out  ADDR_W  address with low log2(NB) bits cleared
mem_be  out  NB  byte enables
mem_wdata  out  XLEN  lane-replicated write data
mem_rvalid  in  1  read data valid
mem_rdata  in  XLEN  read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (synchronous): state IDLE; all outputs 0 except req_ready = 1.
- IDLE: req_ready = 1; a request is accepted on req_valid & req_ready; all request fields are captured.
- On accept, the legality and alignment check runs first:
  - Error → RESP next cycle, with rsp_err = 1 and rsp_rdata = 0; no memory access.
  - Legal → ISSUE next cycle.
- Legal fun3, XLEN=32:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Legal fun3, XLEN=64: additionally load 011 (LD), load 110 (LWU) and store 011 (SD).
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; double requires addr[2:0]=0.
- ISSUE:
  - mem_valid = 1; mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_ready.
  - On mem_valid & mem_ready: a store goes to RESP; a load goes to WAIT.
- Store lanes (off = addr mod NB):
  - mem_be = (1<<size)-1 shifted left by off.
  - mem_wdata = the low size bytes of wdata replicated across all lanes.
- WAIT: mem_rvalid is sampled starting the cycle after the handshake. On mem_rvalid the unit captures (mem_rdata >> 8*off), extends it per fun3 (signed or unsigned), and goes to RESP. For loads, mem_be is all ones.
- RESP: rsp_valid = 1 and response fields are stable until rsp_ready. On rsp_valid & rsp_ready the unit goes to IDLE, so req_ready is 1 the following cycle; there is no back-to-back accept.
- Latency, minimum, accept to rsp_valid:
  - Store: 2 cycles with mem_ready held high.
  - Load: 3 cycles with mem_rvalid arriving the cycle after the handshake.
  - Error: 1 cycle.
- mem_rvalid outside WAIT is ignored. req_valid outside IDLE is ignored.
- Reset mid-operation: the unit returns to IDLE immediately and drops mem_valid; the outstanding transaction is abandoned.
- A stray late mem_rvalid after reset is ignored by the rule above.

Optional Feature:
- Macro LSU_RMW_EN: supports memories without byte enables.
- Defined:
  - A sub-word store becomes a read-modify-write: ISSUE read, then WAIT, then MERGE (replace the selected lanes), then a second ISSUE write with mem_be all ones, then RESP.
  - Full-width stores remain a single write.
  - Minimum sub-word store latency is 5 cycles.
  - Reset during MERGE or the write aborts without any partial write.
- Undefined: stores use byte enables as above, and the MERGE state does not exist.

Test Plan (all with XLEN=32):
1. SB, addr 0x80000006, wdata 0x000000A5 → mem_addr 0x80000004, mem_be 0100, mem_wdata 0xA5A5A5A5, mem_we=1; rsp_valid 2 cycles after accept, rsp_err=0.
2. LB, addr 0x80000003, mem_rdata 0x80FF1234 → rsp_rdata 0xFFFFFF80. The same access as LBU → 0x00000080.
3. LH, addr 0x80000001 → rsp_err=1 and rsp_rdata=0 one cycle after accept; mem_valid never asserts.
4. LW with mem_ready low for 3 cycles and mem_rvalid delayed 4 cycles → request fields stable throughout ISSUE; rsp_rdata equals mem_rdata; rsp held for 2 cycles of rsp_ready=0 with data stable.
5. Reset asserted in WAIT, followed by a late mem_rvalid → outputs return to reset values; no rsp_valid; req_ready=1.
6. With LSU_RMW_EN, SH to 0x80000002, wdata 0xBEEF, memory word 0x11223344 → read, then write of 0xBEEF3344 with mem_be 1111; rsp_valid 5 cycles after accept with zero-wait memory.
